// File: rtl/rr_mux_arbiter_pkg.sv
// Shared types and helpers for the round-robin mux arbiter: FSM states,
// index sizing and a one-hot to binary encoder.
package rr_arb_pkg;

    localparam int MAX_COUNT = 16;
    localparam int IDX_BITS  = 4;

    typedef enum logic [1:0] {
        IDLE,
        OWNED,
        TURN
    } arb_state_e;

    // OR-reduction encoder; a zero input yields index 0.
    function automatic logic [IDX_BITS-1:0] onehot_to_idx(input logic [MAX_COUNT-1:0] onehot);
        logic [IDX_BITS-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_COUNT; i++) begin
            if (onehot[i]) begin
                idx = idx | IDX_BITS'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// Combinational round-robin picker: rotates the request vector so the search
// starts just after last_idx, takes the lowest set bit, then un-rotates.
module rr_pick
    import rr_arb_pkg::*;
#(
    parameter int COUNT = 4
) (
    input  logic [COUNT-1:0]    req,
    input  logic [IDX_BITS-1:0] last_idx,
    output logic [COUNT-1:0]    pick_onehot,
    output logic [IDX_BITS-1:0] pick_idx,
    output logic                pick_valid
);

    logic [2*COUNT-1:0] doubled;
    logic [COUNT-1:0]   rotated;
    int                 start;
    int                 offset;
    int                 sel;

    always_comb begin
        start = (int'(last_idx) >= COUNT - 1) ? 0 : int'(last_idx) + 1;
        doubled = {req, req};
        rotated = COUNT'(doubled >> start);
        offset = 0;
        for (int i = COUNT - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = i;
            end
        end
        sel = start + offset;
        if (sel >= COUNT) begin
            sel = sel - COUNT;
        end
        pick_valid  = |req;
        pick_onehot = '0;
        if (pick_valid) begin
            pick_onehot = COUNT'(1) << sel;
        end
    end

    assign pick_idx = onehot_to_idx(MAX_COUNT'(pick_onehot));

endmodule

// File: rtl/rr_mux_arbiter.sv
// Non-preemptive round-robin owner of a shared one-hot mux select, with an
// optional hold timeout and one forced-idle turnaround cycle between owners.
module rr_mux_arbiter
    import rr_arb_pkg::*;
#(
    parameter  int COUNT     = 4,
    parameter  int MAX_HOLD  = 0,
    localparam int HOLD_BITS = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [COUNT-1:0]    req,
    input  logic [COUNT-1:0]    done,
    output logic [COUNT-1:0]    grant,
    output logic [IDX_BITS-1:0] grant_idx,
    output logic                busy,
    output logic                timeout
);

    arb_state_e           state_q, state_d;
    logic [COUNT-1:0]     grant_q, grant_d;
    logic [IDX_BITS-1:0]  grant_idx_q, grant_idx_d;
    logic                 busy_q, busy_d;
    logic                 timeout_q, timeout_d;
    logic [HOLD_BITS-1:0] hold_q, hold_d;
    logic [IDX_BITS-1:0]  last_idx_q, last_idx_d;

    logic [COUNT-1:0]     pick_onehot;
    logic [IDX_BITS-1:0]  pick_idx;
    logic                 pick_valid;
    logic                 owner_req;
    logic                 owner_done;
    logic                 timer_hit;
    logic                 drop_owner;

    rr_pick #(.COUNT(COUNT)) u_pick (
        .req         (req),
        .last_idx    (last_idx_q),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_valid  (pick_valid)
    );

    // Masking with the registered grant keeps non-owner req/done bits out.
    assign owner_req  = |(req & grant_q);
    assign owner_done = |(done & grant_q);
    assign timer_hit  = (MAX_HOLD != 0) && (hold_q == HOLD_BITS'(MAX_HOLD));
    assign drop_owner = !owner_req || owner_done || timer_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            busy_q      <= 1'b0;
            timeout_q   <= 1'b0;
            hold_q      <= '0;
            last_idx_q  <= IDX_BITS'(COUNT - 1);
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            busy_q      <= busy_d;
            timeout_q   <= timeout_d;
            hold_q      <= hold_d;
            last_idx_q  <= last_idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_valid) state_d = OWNED;
            OWNED:   if (drop_owner) state_d = TURN;
            TURN:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // timeout only flags a release forced purely by the hold counter.
    always_comb begin
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        busy_d      = busy_q;
        timeout_d   = 1'b0;
        hold_d      = hold_q;
        last_idx_d  = last_idx_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d     = pick_onehot;
                    grant_idx_d = pick_idx;
                    busy_d      = 1'b1;
                    hold_d      = HOLD_BITS'(1);
                end
            end
            OWNED: begin
                if (drop_owner) begin
                    grant_d    = '0;
                    busy_d     = 1'b0;
                    hold_d     = '0;
                    last_idx_d = grant_idx_q;
                    timeout_d  = timer_hit && owner_req && !owner_done;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    assign grant     = grant_q;
    assign grant_idx = grant_idx_q;
    assign busy      = busy_q;
    assign timeout   = timeout_q;

    grant_onehot_a: assert property (@(posedge clk) $onehot0(grant_q));

endmodule
